// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide controller.
package muldiv_pkg;
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } mdOp_e;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } mdState_e;

    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;
endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring-division shift registers: one quotient bit per step on unsigned operands.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] abs_dividend,
    input  logic [31:0] abs_divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [31:0] rem, quo, dvs;
    logic [32:0] remShift, trial;
    logic        fits;

    // The dividend is shifted out of the quotient register as quotient bits shift in.
    assign remShift  = {rem, quo[31]};
    assign trial     = remShift - {1'b0, dvs};
    assign fits      = remShift >= {1'b0, dvs};
    assign quotient  = quo;
    assign remainder = rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= abs_dividend;
            dvs <= abs_divisor;
        end else if (step) begin
            rem <= fits ? trial[31:0] : remShift[31:0];
            quo <= {quo[30:0], fits};
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU controller: runs one op off the E stage and pulses the HI/LO write.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT  = 4,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        abort,
    input  logic        hiloaccD,
    input  logic        muldivD,
    output logic        busy,
    output logic        stall_hilo,
    output logic        hilo_we,
    output logic [31:0] Res_hi,
    output logic [31:0] Res_lo
);
    localparam logic [5:0] MUL_LAST  = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST  = 6'(DIV_ITER);
    localparam logic [5:0] DIVZ_LAST = 6'(DIV_ITER + 1);

    mdState_e    state, nextState;
    logic [5:0]  cnt;
    logic        startAcc, sgnMul, sgnDiv, negQ, negR, divZero;
    logic [31:0] absA, absB, dividend, resHi, resLo, quotient, remainder;
    logic [63:0] mulA, mulB, product;

    assign startAcc = (state == IDLE) && startE && !abort;
    assign sgnMul   = (opE == MD_MULT);
    assign sgnDiv   = (opE == MD_DIV);

    // Low 64 bits of the extended product are correct for both signed and unsigned.
    assign mulA    = {{32{sgnMul & srcaE[31]}}, srcaE};
    assign mulB    = {{32{sgnMul & srcbE[31]}}, srcbE};
    assign product = mulA * mulB;

    assign absA = (sgnDiv && srcaE[31]) ? -srcaE : srcaE;
    assign absB = (sgnDiv && srcbE[31]) ? -srcbE : srcbE;

    div_iter uDivIter (
        .clk          (clk),
        .rst          (rst),
        .load         (startAcc && opE[1]),
        .step         (state == DIV),
        .abs_dividend (absA),
        .abs_divisor  (absB),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (startAcc) nextState = opE[1] ? DIV : MUL;
            MUL:  if (cnt == MUL_LAST) nextState = DONE;
            // Divide-by-zero skips FIX but stays one extra cycle in DIV so DONE timing is unchanged.
            DIV:  if (divZero ? (cnt == DIVZ_LAST) : (cnt == DIV_LAST))
                      nextState = divZero ? DONE : FIX;
            FIX:  nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (abort) nextState = IDLE;
    end

    always_comb begin
        busy       = (state != IDLE);
        hilo_we    = (state == DONE);
        stall_hilo = (state != IDLE) && (hiloaccD || muldivD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
            divZero  <= 1'b0;
            dividend <= '0;
            resHi    <= '0;
            resLo    <= '0;
        end else begin
            if (startAcc) begin
                cnt      <= 6'd1;
                negQ     <= sgnDiv && (srcaE[31] ^ srcbE[31]);
                negR     <= sgnDiv && srcaE[31];
                divZero  <= (srcbE == '0);
                dividend <= srcaE;
                if (!opE[1]) {resHi, resLo} <= product;
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + 6'd1;
            end
            if (state == DIV && divZero && cnt == DIVZ_LAST) begin
                resHi <= dividend;
                resLo <= DIV_ZERO_LO;
            end
            if (state == FIX) begin
                resLo <= negQ ? -quotient : quotient;
                resHi <= negR ? -remainder : remainder;
            end
        end
    end

    assign Res_hi = resHi;
    assign Res_lo = resLo;

    // The hazard unit must hold a new mul/div in D while one is in flight.
    assert property (@(posedge clk) disable iff (rst) !(startE && busy));
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops queue expected HI/LO writes, a monitor checks each pulse.
module tb_muldiv_ctrl;
    logic        clk = 1'b0, rst = 1'b1, startE = 1'b0, abort = 1'b0;
    logic        hiloaccD = 1'b0, muldivD = 1'b0;
    logic [1:0]  opE = 2'd0;
    logic [31:0] srcaE = '0, srcbE = '0;
    logic        busy, stall_hilo, hilo_we;
    logic [31:0] Res_hi, Res_lo;

    int tests = 0, fails = 0, pe = 0;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb[$];

    muldiv_ctrl #(.MUL_LAT(4), .DIV_ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .startE     (startE),
        .opE        (opE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .abort      (abort),
        .hiloaccD   (hiloaccD),
        .muldivD    (muldivD),
        .busy       (busy),
        .stall_hilo (stall_hilo),
        .hilo_we    (hilo_we),
        .Res_hi     (Res_hi),
        .Res_lo     (Res_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pe <= pe + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, pe);
        end
    endtask

    // Monitor: every write pulse must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (hilo_we === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_we: got pulse expected none (cycle %0d)", pe);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("we_cycle", 32'(pe), 32'(e.cyc));
                chk("res_hi", Res_hi, e.hi);
                chk("res_lo", Res_lo, e.lo);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue in the current cycle (cycle 0); returns in cycle 1. lat=0 means no write expected.
    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        if (lat > 0) begin
            e.cyc = pe + lat; e.hi = hi; e.lo = lo;
            sb.push_back(e);
        end
        tick(1);
        startE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tick(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall_hilo), 0);
        chk("rst_we", 32'(hilo_we), 0);
        chk("rst_hi", Res_hi, 0);
        chk("rst_lo", Res_lo, 0);
        rst = 1'b0;
        tick(1);

        // MULT -1 x 2, busy cycles 1..4
        start(2'd0, 32'hFFFF_FFFF, 32'h2, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        for (int c = 1; c <= 5; c++) begin
            chk("mul_busy", 32'(busy), 32'(c <= 4));
            tick(1);
        end

        start(2'd1, 32'hFFFF_FFFF, 32'h2, 4, 32'h1, 32'hFFFF_FFFE);
        tick(5);

        // DIV -7/2 with a HI/LO access held in D
        hiloaccD = 1'b1;
        start(2'd2, 32'hFFFF_FFF9, 32'h2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        for (int c = 1; c <= 35; c++) begin
            chk("div_stall", 32'(stall_hilo), 32'(c <= 34));
            tick(1);
        end
        hiloaccD = 1'b0;

        start(2'd3, 32'd100, 32'd7, 34, 32'd2, 32'd14);
        tick(35);
        start(2'd2, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD);
        tick(35);
        start(2'd3, 32'h1234_5678, 32'h0, 34, 32'h1234_5678, 32'hFFFF_FFFF);
        tick(35);
        start(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);
        tick(35);

        muldivD = 1'b1;
        chk("idle_stall", 32'(stall_hilo), 0);
        tick(1);
        muldivD = 1'b0;

        // abort in cycle 10 of a divide, then MULTU 3x5 started in cycle 12
        start(2'd2, 32'd1000, 32'd3, 0, 0, 0);
        tick(9);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_busy11", 32'(busy), 0);
        tick(1);
        chk("abort_busy12", 32'(busy), 0);
        start(2'd1, 32'd3, 32'd5, 4, 32'd0, 32'd15);
        tick(5);

        // abort together with start in IDLE is not accepted
        abort = 1'b1;
        startE = 1'b1; opE = 2'd0; srcaE = 32'd9; srcbE = 32'd9;
        tick(1);
        startE = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 0);
        tick(1);

        // abort during DONE still writes
        start(2'd0, 32'd2, 32'd3, 4, 32'd0, 32'd6);
        tick(3);
        abort = 1'b1;
        chk("abort_done_we", 32'(hilo_we), 1);
        tick(1);
        abort = 1'b0;
        chk("abort_done_busy", 32'(busy), 0);
        tick(1);

        // reset in cycle 5 of a divide
        hiloaccD = 1'b1;
        start(2'd3, 32'd50, 32'd5, 0, 0, 0);
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_stall", 32'(stall_hilo), 0);
        chk("mid_rst_we", 32'(hilo_we), 0);
        chk("mid_rst_hi", Res_hi, 0);
        chk("mid_rst_lo", Res_lo, 0);
        rst = 1'b0;
        hiloaccD = 1'b0;
        tick(40);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle controller for MULT/MULTU/DIV/DIVU; sole producer of HI/LO write data.
- Accepts one operation from the E stage and runs it without stalling younger non-HI/LO instructions.
- Drives a one-cycle HI/LO write pulse to the W-side HI/LO registers, which the existing hi/lo bypass muxes consume.
- Requests a D-stage stall while busy whenever D touches HI/LO or issues a new mul/div.

Parameters:
- MUL_LAT, 4, cycles from start acceptance to the multiply result write pulse; legal range 2..16.
- DIV_ITER, 32, restoring-division iterations; fixed at the data width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- startE  input  1  E-stage mul/div valid (already qualified by the E-stage flush)
- opE  input  2  0=MULT 1=MULTU 2=DIV 3=DIVU
- srcaE  input  32  rs operand (dividend / multiplicand)
- srcbE  input  32  rt operand (divisor / multiplier)
- abort  input  1  exception flush; kills any in-flight operation
- hiloaccD  input  1  D instr is MFHI/MFLO/MTHI/MTLO
- muldivD  input  1  D instr is mul/div
- busy  output  1  operation in flight
- stall_hilo  output  1  stall request to hazard unit
- hilo_we  output  1  one-cycle HI and LO write strobe
- Res_hi  output  32  HI write data
- Res_lo  output  32  LO write data

Behaviour:
- Reset: state IDLE; busy=0, stall_hilo=0, hilo_we=0, Res_hi=0, Res_lo=0; counter and datapath registers cleared.
- Cycle 0 is the cycle in which startE=1 is sampled in IDLE.
- States:
  - IDLE: on startE && !abort, latch operands and op; go to MUL if op<2, else DIV. Otherwise stay.
  - MUL: product is computed and registered at the cycle-0 edge. Wait until the counter reaches MUL_LAT-1, then go to DONE.
  - DIV: unsigned restoring division on absolute values, one quotient bit per cycle, DIV_ITER cycles (cycles 1..32). Then go to FIX.
  - FIX (cycle 33): apply signs for DIV. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend. Go to DONE.
  - DONE: hilo_we=1 for exactly this cycle; Res_hi/Res_lo hold the result. Next state is IDLE.
- Latency: hilo_we is asserted in cycle MUL_LAT for multiply and in cycle 34 for divide.
- busy is 1 from cycle 1 through the DONE cycle inclusive, and 0 otherwise.
- stall_hilo = busy && (hiloaccD || muldivD). It deasserts in the cycle after DONE, so MFHI in D reaches the register file read after the write and is bypassed in W.
- startE while busy: ignored. It cannot occur legally because of stall_hilo; an assertion flags it in simulation.
- Multiply result: 64-bit signed product for MULT, unsigned for MULTU. HI = [63:32], LO = [31:0].
- Division by zero (both signed and unsigned): LO = 32'hFFFFFFFF, HI = dividend unchanged. FIX is skipped; DONE still lands in cycle 34.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- abort in any state: go to IDLE at the next edge with no hilo_we. busy drops in the following cycle.
- abort together with startE in IDLE: start is not accepted.
- abort in the DONE cycle: hilo_we in that cycle is still asserted. The W-stage commit owns cancellation of that write.
- rst in any state forces the full reset values at the next edge, regardless of other inputs.
- Res_hi/Res_lo hold their last values in IDLE and are don't-care whenever hilo_we=0.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
  - state encoding (IDLE, MUL, DIV, FIX, DONE)
  - DIV_ZERO_LO constant
- One sub-module, div_iter: holds the remainder/quotient shift registers. Ports: load, step, abs_dividend, abs_divisor, quotient, remainder. The controller owns the FSM, counter, sign handling and multiply.

Test Plan:
- MULT 0xFFFFFFFF × 0x00000002 -> hilo_we only in cycle 4; Res_hi=0xFFFFFFFF, Res_lo=0xFFFFFFFE; busy high cycles 1..4.
- MULTU 0xFFFFFFFF × 0x00000002 -> Res_hi=0x00000001, Res_lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> hilo_we in cycle 34; Res_lo=0xFFFFFFFD, Res_hi=0xFFFFFFFF. DIVU 100/7 -> Res_lo=0x0000000E, Res_hi=0x00000002.
- DIVU 0x12345678 / 0 -> Res_lo=0xFFFFFFFF, Res_hi=0x12345678, cycle 34. DIV 0x80000000 / 0xFFFFFFFF -> Res_lo=0x80000000, Res_hi=0.
- DIV started, abort in cycle 10 -> no hilo_we ever; busy=0 in cycle 12. A new MULTU 3×5 started in cycle 12 gives Res_lo=15 and Res_hi=0 at cycle 16.
- Hazard/reset:
  - hiloaccD=1 during divide -> stall_hilo=1 cycles 1..34, 0 in cycle 35.
  - muldivD=1 with busy=0 -> stall_hilo=0.
  - rst in cycle 5 of a divide -> all outputs 0 next cycle, no hilo_we.
